uart_tx_frame: RTL

Parametrised UART transmitter: parallel word in, serial frame out (start, DATA_W data bits LSB first, optional even/odd parity, 1 or 2 stop bits). Bit period is set at run time by a prescale input. It replaces the fixed 8-bit/1x-tick transmitter, with a self-contained baud counter, selectable parity type and stop length. It sits between the register/FIFO front end and the TX pad.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_baud_cnt.sv | 54 +++++
 rtl/uart_tx_frame.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the parametrised UART transmitter.
package uart_tx_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_PRESCALE_W = 16;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: latches the frame's prescale (0 read as 1) and flags the last
// clock of each bit, plus a look-ahead flag telling whether the next clock is a last clock.
module uart_tx_baud_cnt
   import uart_tx_pkg::*;
#(
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  i_load,
   input  logic                  i_en,
   input  logic [PRESCALE_W-1:0] i_prescale,
   output logic                  o_bit_tick,
   output logic                  o_tick_next
);

   logic [PRESCALE_W-1:0] r_cnt;
   logic [PRESCALE_W-1:0] r_last;
   logic [PRESCALE_W-1:0] w_last_in;

   // Terminal count is stored as P-1 so a prescale of 0 and 1 both give one-clock bits
   assign w_last_in  = (i_prescale == '0) ? '0 : (i_prescale - PRESCALE_W'(1));
   assign o_bit_tick = (r_cnt == r_last);

   // Predict whether the following clock will be the last clock of a bit
   always_comb begin
      o_tick_next = 1'b0;
      if (i_load) begin
         o_tick_next = (w_last_in == '0);
      end else if (!i_en) begin
         o_tick_next = 1'b0;
      end else if (o_bit_tick) begin
         o_tick_next = (r_last == '0);
      end else begin
         o_tick_next = ((r_cnt + PRESCALE_W'(1)) == r_last);
      end
   end

   // Count 0..P-1 within each bit, restart on every tick and hold at 0 while idle
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt  <= '0;
         r_last <= '0;
      end else if (i_load) begin
         r_cnt  <= '0;
         r_last <= w_last_in;
      end else if (!i_en || o_bit_tick) begin
         r_cnt  <= '0;
      end else begin
         r_cnt  <= r_cnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises a latched word as start bit, DATA_W data bits LSB first,
// optional even/odd parity and one or two stop bits, at a run-time bit period.
module uart_tx_frame
   import uart_tx_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_W-1:0]     P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   output logic                  TX_OUT,
   output logic                  Busy,
   output logic                  TX_DONE
);

   localparam int               CNT_W     = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

   tx_state_e          r_state;
   tx_state_e          w_state_nxt;
   logic [DATA_W-1:0]  r_shift;
   logic [DATA_W-1:0]  w_shift_nxt;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic [CNT_W-1:0]   w_bit_cnt_nxt;
   logic [CNT_W-1:0]   w_stop_last;
   logic               r_par_en;
   logic               r_par_bit;
   logic               r_stop2;
   logic               r_tx_out;
   logic               r_busy;
   logic               r_done;
   logic               w_tx_nxt;
   logic               w_done_nxt;
   logic               w_load;
   logic               w_cnt_en;
   logic               w_bit_tick;
   logic               w_tick_next;

   function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic typ);
      calc_parity = (typ == PAR_EVEN) ? (^data) : ~(^data);
   endfunction

   assign w_cnt_en    = (r_state != IDLE);
   assign w_stop_last = {{(CNT_W-1){1'b0}}, r_stop2};

   uart_tx_baud_cnt #(
      .PRESCALE_W (PRESCALE_W)
   ) u_baud (
      .CLK         (CLK),
      .RST         (RST),
      .i_load      (w_load),
      .i_en        (w_cnt_en),
      .i_prescale  (PRESCALE),
      .o_bit_tick  (w_bit_tick),
      .o_tick_next (w_tick_next)
   );

   // Next-state, shift/bit-count update and the line value for the coming clock
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_load        = 1'b0;
      w_tx_nxt      = 1'b1;
      w_done_nxt    = 1'b0;

      case (r_state)
         IDLE: begin
            if (DATA_VALID) begin
               w_state_nxt = START;
               w_shift_nxt = P_DATA;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         START: begin
            if (w_bit_tick) begin
               w_state_nxt   = DATA;
               w_bit_cnt_nxt = '0;
            end else begin
               w_state_nxt = START;
            end
         end
         DATA: begin
            if (w_bit_tick && (r_bit_cnt == LAST_DATA)) begin
               w_state_nxt   = r_par_en ? PARITY : STOP;
               w_bit_cnt_nxt = '0;
            end else if (w_bit_tick) begin
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
            end else begin
               w_state_nxt = DATA;
            end
         end
         PARITY: begin
            if (w_bit_tick) begin
               w_state_nxt   = STOP;
               w_bit_cnt_nxt = '0;
            end else begin
               w_state_nxt = PARITY;
            end
         end
         STOP: begin
            if (w_bit_tick && (r_bit_cnt == w_stop_last)) begin
               w_state_nxt = IDLE;
            end else if (w_bit_tick) begin
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end else begin
               w_state_nxt = STOP;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         PARITY:  w_tx_nxt = r_par_bit;
         default: w_tx_nxt = 1'b1;
      endcase

      // Done marks the final clock of the final stop bit, so it is raised one clock ahead
      if ((w_state_nxt == STOP) && w_tick_next && (w_bit_cnt_nxt == w_stop_last)) begin
         w_done_nxt = 1'b1;
      end else begin
         w_done_nxt = 1'b0;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
         r_stop2   <= 1'b0;
         r_tx_out  <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_tx_out  <= w_tx_nxt;
         r_busy    <= (w_state_nxt != IDLE);
         r_done    <= w_done_nxt;
         if (w_load) begin
            r_par_en  <= PAR_EN;
            r_par_bit <= calc_parity(P_DATA, PAR_TYP);
            r_stop2   <= STOP2;
         end else begin
            r_par_en  <= r_par_en;
            r_par_bit <= r_par_bit;
            r_stop2   <= r_stop2;
         end
      end
   end

   assign TX_OUT  = r_tx_out;
   assign Busy    = r_busy;
   assign TX_DONE = r_done;

endmodule
